gpio_irq_ctrl: RTL and testbench

//  Consumer end of the per-pin GPIO interrupt lines. Samples the NUM_PINS INTR vector from the
//  pin mux, masks it, picks one pending pin by fixed priority and presents it to the CPU with an
//  IRQ/ACK handshake. On ACK it drives a one-cycle IRQRES pulse back to that pin's GPIO latch and

---
 rtl/gpio_irq_pkg.sv | 16 +
 rtl/gpio_irq_prio_enc.sv | 21 ++
 rtl/gpio_irq_ctrl.sv | 151 +++++++++++++++
 tb/tb_gpio_irq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_irq_pkg.sv
// Shared types and default sizing for the GPIO interrupt controller.
// The FSM state enum and the default pin, id and timeout parameters live here.
package gpio_irq_pkg;

  localparam int NUM_PINS_DEF = 24;
  localparam int ID_W_DEF     = 5;
  localparam int DROP_TMO_DEF = 15;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    CLEAR     = 2'd2,
    WAIT_DROP = 2'd3
  } irq_state_e;

endpackage : gpio_irq_pkg

// File: rtl/gpio_irq_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set request index wins.
module gpio_irq_prio_enc #(
  parameter int N  = 24,
  parameter int IW = 5
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx   = req[i] ? IW'(i) : idx;
      valid = valid | req[i];
    end
  end

endmodule : gpio_irq_prio_enc

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt consumer: samples the per-pin lines, arbitrates one pending pin,
// hands it to the CPU with an IRQ/ACK handshake, pulses its clear and watches it drop.
module gpio_irq_ctrl
  import gpio_irq_pkg::*;
#(
  parameter int NUM_PINS = NUM_PINS_DEF,
  parameter int ID_W     = ID_W_DEF,
  parameter int DROP_TMO = DROP_TMO_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PINS-1:0] intr,
  input  logic [NUM_PINS-1:0] irq_mask,
  output logic [NUM_PINS-1:0] irqres,
  output logic                cpu_irq,
  output logic [ID_W-1:0]     cpu_irq_id,
  input  logic                cpu_ack,
  output logic [NUM_PINS-1:0] stuck,
  input  logic                stuck_clr
);

  localparam int CNT_W = $clog2(DROP_TMO + 1);
  localparam logic [NUM_PINS-1:0] ONE_PIN = NUM_PINS'(1);

  irq_state_e          state_r;
  irq_state_e          state_s;
  logic [NUM_PINS-1:0] intr_q_r;
  logic [NUM_PINS-1:0] stuck_r;
  logic [NUM_PINS-1:0] pend_s;
  logic [NUM_PINS-1:0] id_onehot_s;
  logic [NUM_PINS-1:0] stuck_set_s;
  logic [ID_W-1:0]     id_q_r;
  logic [ID_W-1:0]     win_idx_s;
  logic                win_valid_s;
  logic [CNT_W-1:0]    cnt_r;
  logic                cur_pend_s;
  logic                cur_line_s;
  logic                tmo_hit_s;

  assign pend_s      = intr_q_r & irq_mask & ~stuck_r;
  assign id_onehot_s = ONE_PIN << id_q_r;
  assign cur_pend_s  = |(pend_s & id_onehot_s);
  assign cur_line_s  = |(intr_q_r & id_onehot_s);
  // The counter exits on reaching DROP_TMO, so the hit is one below it before the increment.
  assign tmo_hit_s   = (cnt_r == CNT_W'(DROP_TMO - 1));
  assign stuck_set_s = ((state_r == WAIT_DROP) && cur_line_s && tmo_hit_s) ? id_onehot_s
                                                                           : '0;

  assign cpu_irq_id  = id_q_r;
  assign stuck       = stuck_r;

  gpio_irq_prio_enc #(
    .N  (NUM_PINS),
    .IW (ID_W)
  ) u_prio_enc (
    .req   (pend_s),
    .valid (win_valid_s),
    .idx   (win_idx_s)
  );

  // Input sync stage for the interrupt lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_q_r <= '0;
    end else begin
      intr_q_r <= intr;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; a same-cycle ACK beats a withdraw in REQ.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) state_s = REQ;
        else             state_s = IDLE;
      end
      REQ: begin
        if (cpu_ack)          state_s = CLEAR;
        else if (!cur_pend_s) state_s = IDLE;
        else                  state_s = REQ;
      end
      CLEAR: state_s = WAIT_DROP;
      WAIT_DROP: begin
        if (!cur_line_s)    state_s = IDLE;
        else if (tmo_hit_s) state_s = IDLE;
        else                state_s = WAIT_DROP;
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    cpu_irq = 1'b0;
    irqres  = '0;
    case (state_r)
      REQ:   cpu_irq = 1'b1;
      CLEAR: irqres  = id_onehot_s;
      default: begin
        cpu_irq = 1'b0;
        irqres  = '0;
      end
    endcase
  end

  // Winner capture; id_q holds between services so CPU_IRQ_ID stays at the last pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q_r <= '0;
    end else if ((state_r == IDLE) && win_valid_s) begin
      id_q_r <= win_idx_s;
    end else begin
      id_q_r <= id_q_r;
    end
  end

  // Drop timeout counter, restarted on every clear pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (state_r == CLEAR) begin
      cnt_r <= '0;
    end else if ((state_r == WAIT_DROP) && cur_line_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sticky stuck flags; a clear request wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuck_r <= '0;
    end else if (stuck_clr) begin
      stuck_r <= '0;
    end else begin
      stuck_r <= stuck_r | stuck_set_s;
    end
  end

endmodule : gpio_irq_ctrl

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl: directed scenarios with literal expectations
// plus a cycle-level behavioural model compared against the outputs every cycle.
module tb_gpio_irq_ctrl;

  localparam int NP       = 24;
  localparam int IDW      = 5;
  localparam int DROP_TMO = 15;

  logic          clk;
  logic          rst_n;
  logic [NP-1:0] intr;
  logic [NP-1:0] irq_mask;
  logic [NP-1:0] irqres;
  logic          cpu_irq;
  logic [IDW-1:0] cpu_irq_id;
  logic          cpu_ack;
  logic [NP-1:0] stuck;
  logic          stuck_clr;

  int n_checks = 0;
  int n_errors = 0;

  gpio_irq_ctrl #(.NUM_PINS(NP), .ID_W(IDW), .DROP_TMO(DROP_TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .intr       (intr),
    .irq_mask   (irq_mask),
    .irqres     (irqres),
    .cpu_irq    (cpu_irq),
    .cpu_irq_id (cpu_irq_id),
    .cpu_ack    (cpu_ack),
    .stuck      (stuck),
    .stuck_clr  (stuck_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model. phase: 0 waiting, 1 presenting to CPU, 2 clear pulse, 3 draining.
  typedef struct {
    int            phase;
    int            id;
    int            cnt;
    logic [NP-1:0] stuck;
  } mstate_t;

  mstate_t       m;
  logic [NP-1:0] m_iq;

  function automatic mstate_t next_model(mstate_t s, logic [NP-1:0] iq, logic [NP-1:0] mask,
                                         logic ack, logic clr);
    mstate_t       n     = s;
    logic [NP-1:0] pend  = iq & mask & ~s.stuck;
    logic [NP-1:0] newly = '0;
    int            w     = -1;
    for (int i = NP - 1; i >= 0; i--) if (pend[i]) w = i;
    case (s.phase)
      0: if (w >= 0) begin n.phase = 1; n.id = w; end
      1: begin
        if (ack) n.phase = 2;
        else if (!pend[s.id]) n.phase = 0;
      end
      2: begin n.cnt = 0; n.phase = 3; end
      3: begin
        if (!iq[s.id]) n.phase = 0;
        else begin
          n.cnt = s.cnt + 1;
          if (n.cnt == DROP_TMO) begin
            newly[s.id] = 1'b1;
            n.phase = 0;
          end
        end
      end
      default: n.phase = 0;
    endcase
    n.stuck = clr ? '0 : (s.stuck | newly);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m    <= '{phase: 0, id: 0, cnt: 0, stuck: '0};
      m_iq <= '0;
    end else begin
      m    <= next_model(m, m_iq, irq_mask, cpu_ack, stuck_clr);
      m_iq <= intr;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [NP-1:0] e_res;
    e_res = (m.phase == 2) ? (NP'(1) << m.id) : '0;
    n_checks++;
    if (cpu_irq !== (m.phase == 1) || 32'(cpu_irq_id) != m.id ||
        irqres !== e_res || stuck !== m.stuck) begin
      n_errors++;
      $display("FAIL model t=%0t: irq=%0b id=%0d irqres=%h stuck=%h, required irq=%0b id=%0d irqres=%h stuck=%h",
               $time, cpu_irq, cpu_irq_id, irqres, stuck, (m.phase == 1), m.id, e_res, m.stuck);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic ack_pulse();
    cpu_ack = 1'b1;
    step(1);
    cpu_ack = 1'b0;
  endtask

  task automatic wait_irq(input string name, input int exp_id, input int budget);
    int k = 0;
    while (cpu_irq !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    chk({name, "_irq"}, 32'(cpu_irq), 32'd1);
    chk({name, "_id"}, 32'(cpu_irq_id), 32'(exp_id));
  endtask

  initial begin
    rst_n = 1'b0; intr = '0; irq_mask = '0; cpu_ack = 1'b0; stuck_clr = 1'b0;
    step(2);
    chk("rst_irq", 32'(cpu_irq), 32'd0);
    chk("rst_id", 32'(cpu_irq_id), 32'd0);
    chk("rst_irqres", 32'(irqres), 32'd0);
    chk("rst_stuck", 32'(stuck), 32'd0);
    rst_n = 1'b1; irq_mask = 24'hFFFFFF;
    step(1);

    // Single line, 2-cycle latency, clear pulse, drop.
    intr = 24'h000020;
    step(1); chk("t1_lat1", 32'(cpu_irq), 32'd0);
    step(1); chk("t1_irq", 32'(cpu_irq), 32'd1); chk("t1_id", 32'(cpu_irq_id), 32'd5);
    ack_pulse();
    chk("t1_irqres", 32'(irqres), 32'h000020); chk("t1_irq_clr", 32'(cpu_irq), 32'd0);
    step(1); chk("t1_irqres_off", 32'(irqres), 32'd0);
    intr = '0;
    step(5); chk("t1_idle", 32'(cpu_irq), 32'd0);

    // Two lines together: lower index first, then the other.
    intr = 24'h020008;
    step(2); chk("t2_first", 32'(cpu_irq_id), 32'd3); chk("t2_irq", 32'(cpu_irq), 32'd1);
    ack_pulse(); chk("t2_res3", 32'(irqres), 32'h000008);
    intr = 24'h020000;
    step(1); chk("t2_gap", 32'(cpu_irq), 32'd0);
    step(2); chk("t2_second_irq", 32'(cpu_irq), 32'd1); chk("t2_second", 32'(cpu_irq_id), 32'd17);
    ack_pulse(); chk("t2_res17", 32'(irqres), 32'h020000);
    intr = '0;
    step(4);

    // Withdraw by masking while presented.
    intr = 24'h000200;
    step(2); chk("t3_irq", 32'(cpu_irq), 32'd1); chk("t3_id", 32'(cpu_irq_id), 32'd9);
    irq_mask = 24'hFFFDFF;
    step(1); chk("t3_withdraw", 32'(cpu_irq), 32'd0); chk("t3_nores", 32'(irqres), 32'd0);
    chk("t3_id_hold", 32'(cpu_irq_id), 32'd9);
    intr = '0;
    step(1); chk("t3_nores2", 32'(irqres), 32'd0);
    step(2); irq_mask = 24'hFFFFFF;
    step(2); chk("t3_idle", 32'(cpu_irq), 32'd0);

    // Line held after clear goes stuck after the timeout; stuck clear retries it.
    intr = 24'h000001;
    step(2); chk("t4_irq", 32'(cpu_irq), 32'd1); chk("t4_id", 32'(cpu_irq_id), 32'd0);
    ack_pulse(); chk("t4_res", 32'(irqres), 32'h000001);
    step(15); chk("t4_not_yet", 32'(stuck), 32'd0);
    step(1); chk("t4_stuck", 32'(stuck), 32'h000001);
    step(3); chk("t4_no_present", 32'(cpu_irq), 32'd0);
    stuck_clr = 1'b1;
    step(1); stuck_clr = 1'b0; chk("t4_clr", 32'(stuck), 32'd0);
    step(1); chk("t4_retry", 32'(cpu_irq), 32'd1); chk("t4_retry_id", 32'(cpu_irq_id), 32'd0);
    ack_pulse();
    step(16); chk("t4_stuck_again", 32'(stuck), 32'h000001);

    // Reset during CLEAR.
    intr = 24'h001001;
    step(2); chk("t5_id", 32'(cpu_irq_id), 32'd12); chk("t5_irq", 32'(cpu_irq), 32'd1);
    ack_pulse(); chk("t5_res", 32'(irqres), 32'h001000);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_res", 32'(irqres), 32'd0); chk("t5_rst_irq", 32'(cpu_irq), 32'd0);
    chk("t5_rst_stuck", 32'(stuck), 32'd0);
    step(1); rst_n = 1'b1;
    step(1); chk("t5_lat1", 32'(cpu_irq), 32'd0);
    step(1); chk("t5_re_irq", 32'(cpu_irq), 32'd1); chk("t5_re_id", 32'(cpu_irq_id), 32'd0);
    ack_pulse(); chk("t5_res0", 32'(irqres), 32'h000001);
    intr = 24'h001000;
    wait_irq("t5_next", 12, 10);
    ack_pulse(); chk("t5_res12", 32'(irqres), 32'h001000);
    intr = '0;
    step(4);

    // ACK outside REQ is ignored.
    ack_pulse(); chk("t6_idle_res", 32'(irqres), 32'd0); chk("t6_idle_irq", 32'(cpu_irq), 32'd0);
    step(1);
    intr = 24'h000080;
    step(2); chk("t6_id", 32'(cpu_irq_id), 32'd7);
    ack_pulse(); chk("t6_res", 32'(irqres), 32'h000080);
    step(1);
    ack_pulse(); chk("t6_wd_res", 32'(irqres), 32'd0); chk("t6_wd_irq", 32'(cpu_irq), 32'd0);
    intr = '0;
    step(4); chk("t6_end_irq", 32'(cpu_irq), 32'd0); chk("t6_end_stuck", 32'(stuck), 32'd0);
    step(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_gpio_irq_ctrl
